rv32_chip: RTL and testbench



---
 rtl/rv32_chip_pkg.sv | 25 ++
 rtl/rv32_regfile.sv | 32 +++
 rtl/rv32_chip.sv | 202 ++++++++++++++++++++
 tb/tb_rv32_chip.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_chip_pkg.sv
// rtl/rv32_chip_pkg.sv - opcodes, ALU operations and reset constants for rv32_chip
package rv32_chip_pkg;

  localparam logic [31:0] PC_RESET = 32'h0001_0000;
  localparam logic [31:0] SP_RESET = 32'hBFFF_FFF0;
  localparam logic [31:0] GP_RESET = 32'h1000_8000;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASSB, ALU_MUL
  } alu_op_t;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_t;

endpackage

// File: rtl/rv32_regfile.sv
// rtl/rv32_regfile.sv - 32x32 register file, two combinational reads, one clocked write
module rv32_regfile
  import rv32_chip_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs [0:31];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      regs[2] <= SP_RESET;
      regs[3] <= GP_RESET;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  // no bypass: a read in the write cycle sees the old value
  assign rd1 = (ra1 == 5'd0) ? 32'h0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'h0 : regs[ra2];

endmodule

// File: rtl/rv32_chip.sv
// rtl/rv32_chip.sv - single-cycle RV32I-subset core with Harvard ports
// Define CHIP_MUL_EN to add the mul instruction.
module rv32_chip
  import rv32_chip_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_wen_D,
  output logic [31:0] mem_addr_D,
  output logic [31:0] mem_wdata_D,
  input  logic [31:0] mem_rdata_D,
  output logic [31:0] mem_addr_I,
  input  logic [31:0] mem_rdata_I
);

  logic [31:0] pc, pc_plus4, pc_next, instr;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sel;
  logic [31:0] rs1_val, rs2_val, op_a, op_b, alu_res, wb_data;
  logic        src_a_pc, src_b_imm, reg_we, is_store, is_branch, is_jal, is_jalr, br_cond;
  alu_op_t     alu_op;
  wb_sel_t     wb_sel;

  assign instr  = mem_rdata_I;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    alu_op    = ALU_ADD;
    src_a_pc  = 1'b0;
    src_b_imm = 1'b0;
    imm_sel   = imm_i;
    reg_we    = 1'b0;
    wb_sel    = WB_ALU;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    case (opcode)
      OP: begin
        reg_we = 1'b1;
        case ({funct7, funct3})
          {7'h00, 3'b000}: alu_op = ALU_ADD;
          {7'h20, 3'b000}: alu_op = ALU_SUB;
          {7'h00, 3'b111}: alu_op = ALU_AND;
          {7'h00, 3'b110}: alu_op = ALU_OR;
          {7'h00, 3'b100}: alu_op = ALU_XOR;
          {7'h00, 3'b010}: alu_op = ALU_SLT;
          {7'h00, 3'b001}: alu_op = ALU_SLL;
          {7'h00, 3'b101}: alu_op = ALU_SRL;
          {7'h20, 3'b101}: alu_op = ALU_SRA;
`ifdef CHIP_MUL_EN
          {7'h01, 3'b000}: alu_op = ALU_MUL;
`endif
          default:         reg_we = 1'b0;
        endcase
      end
      OP_IMM: begin
        reg_we    = 1'b1;
        src_b_imm = 1'b1;
        case (funct3)
          3'b000:  alu_op = ALU_ADD;
          3'b010:  alu_op = ALU_SLT;
          3'b100:  alu_op = ALU_XOR;
          3'b110:  alu_op = ALU_OR;
          3'b111:  alu_op = ALU_AND;
          3'b001: begin
            if (funct7 == 7'h00) alu_op = ALU_SLL;
            else                 reg_we = 1'b0;
          end
          3'b101: begin
            if (funct7 == 7'h00)      alu_op = ALU_SRL;
            else if (funct7 == 7'h20) alu_op = ALU_SRA;
            else                      reg_we = 1'b0;
          end
          default: reg_we = 1'b0;
        endcase
      end
      LOAD: if (funct3 == 3'b010) begin
        reg_we    = 1'b1;
        src_b_imm = 1'b1;
        wb_sel    = WB_MEM;
      end
      STORE: if (funct3 == 3'b010) begin
        is_store  = 1'b1;
        src_b_imm = 1'b1;
        imm_sel   = imm_s;
      end
      BRANCH: is_branch = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                          (funct3 == 3'b100) || (funct3 == 3'b101);
      JAL: begin
        is_jal = 1'b1;
        reg_we = 1'b1;
        wb_sel = WB_PC4;
      end
      JALR: if (funct3 == 3'b000) begin
        is_jalr   = 1'b1;
        reg_we    = 1'b1;
        wb_sel    = WB_PC4;
        src_b_imm = 1'b1;
      end
      LUI: begin
        reg_we    = 1'b1;
        src_b_imm = 1'b1;
        imm_sel   = imm_u;
        alu_op    = ALU_PASSB;
      end
      AUIPC: begin
        reg_we    = 1'b1;
        src_a_pc  = 1'b1;
        src_b_imm = 1'b1;
        imm_sel   = imm_u;
      end
      default: ;
    endcase
  end

  rv32_regfile u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (rs1),
    .ra2   (rs2),
    .wa    (rd),
    .we    (reg_we),
    .wd    (wb_data),
    .rd1   (rs1_val),
    .rd2   (rs2_val)
  );

  assign op_a = src_a_pc  ? pc      : rs1_val;
  assign op_b = src_b_imm ? imm_sel : rs2_val;

  always_comb begin
    case (alu_op)
      ALU_ADD:   alu_res = op_a + op_b;
      ALU_SUB:   alu_res = op_a - op_b;
      ALU_AND:   alu_res = op_a & op_b;
      ALU_OR:    alu_res = op_a | op_b;
      ALU_XOR:   alu_res = op_a ^ op_b;
      ALU_SLT:   alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
      ALU_SLL:   alu_res = op_a << op_b[4:0];
      ALU_SRL:   alu_res = op_a >> op_b[4:0];
      ALU_SRA:   alu_res = $signed(op_a) >>> op_b[4:0];
      ALU_PASSB: alu_res = op_b;
`ifdef CHIP_MUL_EN
      ALU_MUL:   alu_res = op_a * op_b;
`endif
      default:   alu_res = op_a + op_b;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  br_cond = (rs1_val == rs2_val);
      3'b001:  br_cond = (rs1_val != rs2_val);
      3'b100:  br_cond = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  br_cond = ($signed(rs1_val) >= $signed(rs2_val));
      default: br_cond = 1'b0;
    endcase
  end

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    pc_next = pc_plus4;
    if (is_jal)                    pc_next = pc + imm_j;
    else if (is_jalr)              pc_next = {alu_res[31:1], 1'b0};
    else if (is_branch && br_cond) pc_next = pc + imm_b;
  end

  always_comb begin
    case (wb_sel)
      WB_MEM:  wb_data = mem_rdata_D;
      WB_PC4:  wb_data = pc_plus4;
      default: wb_data = alu_res;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pc <= PC_RESET;
    else        pc <= pc_next;
  end

  // gating with rst_n keeps a store in flight from committing on a reset edge
  assign mem_wen_D   = is_store & rst_n;
  assign mem_addr_D  = alu_res;
  assign mem_wdata_D = rs2_val;
  assign mem_addr_I  = pc;

endmodule

// File: tb/tb_rv32_chip.sv
// tb/tb_rv32_chip.sv - directed self-checking bench for rv32_chip
module tb_rv32_chip;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [6:0]  O_OP    = 7'h33;
  localparam logic [6:0]  O_IMM   = 7'h13;
  localparam logic [6:0]  O_LOAD  = 7'h03;
  localparam logic [6:0]  O_STORE = 7'h23;
  localparam logic [6:0]  O_BR    = 7'h63;
  localparam logic [6:0]  O_JAL   = 7'h6F;
  localparam logic [6:0]  O_JALR  = 7'h67;
  localparam logic [6:0]  O_LUI   = 7'h37;
  localparam logic [6:0]  O_AUIPC = 7'h17;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_wen_D;
  logic [31:0] mem_addr_D, mem_wdata_D, mem_rdata_D, mem_addr_I, mem_rdata_I;

  logic [31:0] imem [0:255];
  logic [31:0] dmem [0:63];
  logic [31:0] smem [0:63];
  logic [31:0] iofs;
  logic [31:0] st_addr [$];
  logic [31:0] st_data [$];
  logic [31:0] trace [$];
  logic [31:0] max_pc;
  logic [31:0] alu_exp [0:15];
  logic [31:0] cf_exp [0:11];
  int          total = 0;
  int          bad = 0;
  int          p = 0;

  always #5 clk = ~clk;

  rv32_chip dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_wen_D   (mem_wen_D),
    .mem_addr_D  (mem_addr_D),
    .mem_wdata_D (mem_wdata_D),
    .mem_rdata_D (mem_rdata_D),
    .mem_addr_I  (mem_addr_I),
    .mem_rdata_I (mem_rdata_I)
  );

  assign iofs        = mem_addr_I - 32'h0001_0000;
  assign mem_rdata_I = (iofs < 32'd1024) ? imem[iofs[9:2]] : NOP;
  assign mem_rdata_D = (mem_addr_D[31:8] == 24'h100080) ? dmem[mem_addr_D[7:2]] :
                       (mem_addr_D[31:8] == 24'hBFFFFF) ? smem[mem_addr_D[7:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_wen_D) begin
      if (mem_addr_D[31:8] == 24'h100080)      dmem[mem_addr_D[7:2]] <= mem_wdata_D;
      else if (mem_addr_D[31:8] == 24'hBFFFFF) smem[mem_addr_D[7:2]] <= mem_wdata_D;
      st_addr.push_back(mem_addr_D);
      st_data.push_back(mem_wdata_D);
    end
  end

  function automatic logic [31:0] r_t(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], O_OP};
  endfunction

  function automatic logic [31:0] i_t(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction

  function automatic logic [31:0] s_w(input int imm, input int rs2, input int rs1);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], O_STORE};
  endfunction

  function automatic logic [31:0] b_t(input int imm, input int rs1, input int rs2, input int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], O_BR};
  endfunction

  function automatic logic [31:0] j_t(input int imm, input int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], O_JAL};
  endfunction

  function automatic logic [31:0] u_t(input int imm20, input int rd, input logic [6:0] op);
    return {imm20[19:0], rd[4:0], op};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic emit(input logic [31:0] w);
    imem[p] = w;
    p++;
  endtask

  task automatic clear_mem;
    for (int i = 0; i < 256; i++) imem[i] = NOP;
    for (int i = 0; i < 64; i++) begin
      dmem[i] = 32'h0;
      smem[i] = 32'h0;
    end
    p = 0;
    st_addr.delete();
    st_data.delete();
  endtask

  task automatic reset_cpu;
    rst_n = 1'b0;
    step;
    step;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic run_to(input logic [31:0] stop_pc, input int budget, input string tag);
    int n;
    n = 0;
    trace.delete();
    max_pc = 32'h0;
    while (mem_addr_I != stop_pc && n < budget) begin
      trace.push_back(mem_addr_I);
      if (mem_addr_I > max_pc) max_pc = mem_addr_I;
      step;
      n++;
    end
    check({tag, "_reach"}, mem_addr_I, stop_pc);
  endtask

  initial begin
    // reset with a store sitting at the reset vector
    clear_mem;
    emit(s_w(0, 3, 3));
    rst_n = 1'b0;
    step;
    step;
    check("rst_pc", mem_addr_I, 32'h0001_0000);
    check("rst_wen", {31'b0, mem_wen_D}, 32'd0);
    check("rst_nostore", st_addr.size(), 32'd0);
    rst_n = 1'b1;
    #1;
    check("gp_wen", {31'b0, mem_wen_D}, 32'd1);
    check("gp_addr", mem_addr_D, 32'h1000_8000);
    check("gp_wdata", mem_wdata_D, 32'h1000_8000);
    step;
    check("pc_step1", mem_addr_I, 32'h0001_0004);
    check("wen_nop", {31'b0, mem_wen_D}, 32'd0);
    step;
    check("pc_step2", mem_addr_I, 32'h0001_0008);
    check("gp_store_cnt", st_addr.size(), 32'd1);
    check("gp_store_mem", dmem[0], 32'h1000_8000);

    // ALU patterns, each result stored to the data base
    clear_mem;
    emit(i_t(7, 0, 0, 5, O_IMM));
    emit(i_t(-3, 0, 0, 6, O_IMM));
    emit(r_t(0, 6, 5, 0, 7));
    emit(r_t(0, 5, 6, 2, 8));
    emit(s_w(0, 7, 3));
    emit(s_w(4, 8, 3));
    emit(r_t(32, 5, 6, 0, 10));
    emit(s_w(8, 10, 3));
    emit(i_t(32'h401, 6, 5, 11, O_IMM));
    emit(s_w(12, 11, 3));
    emit(i_t(28, 6, 5, 12, O_IMM));
    emit(s_w(16, 12, 3));
    emit(u_t(32'h12345, 13, O_LUI));
    emit(s_w(20, 13, 3));
    emit(u_t(1, 14, O_AUIPC));
    emit(s_w(24, 14, 3));
    emit(i_t(-1, 5, 4, 15, O_IMM));
    emit(s_w(28, 15, 3));
    emit(r_t(0, 5, 5, 1, 16));
    emit(s_w(32, 16, 3));
    emit(i_t(0, 6, 2, 17, O_IMM));
    emit(s_w(36, 17, 3));
    emit(r_t(32, 5, 6, 5, 18));
    emit(s_w(40, 18, 3));
    emit(r_t(0, 5, 6, 5, 19));
    emit(s_w(44, 19, 3));
    emit(r_t(0, 6, 5, 7, 20));
    emit(s_w(48, 20, 3));
    emit(r_t(0, 6, 5, 4, 21));
    emit(s_w(52, 21, 3));
    emit(i_t(32'hF0, 6, 7, 22, O_IMM));
    emit(s_w(56, 22, 3));
    emit(r_t(0, 13, 5, 6, 23));
    emit(s_w(60, 23, 3));
    alu_exp = '{32'h0000_0004, 32'h0000_0001, 32'hFFFF_FFF6, 32'hFFFF_FFFE,
                32'h0000_000F, 32'h1234_5000, 32'h0001_1038, 32'hFFFF_FFF8,
                32'h0000_0380, 32'h0000_0001, 32'hFFFF_FFFF, 32'h01FF_FFFF,
                32'h0000_0005, 32'hFFFF_FFFA, 32'h0000_00F0, 32'h1234_5007};
    reset_cpu;
    run_to(32'h0001_0088, 100, "alu");
    for (int i = 0; i < 16; i++) check($sformatf("alu_%0d", i), dmem[i], alu_exp[i]);

    // load/store through the stack
    clear_mem;
    emit(i_t(7, 0, 0, 5, O_IMM));
    emit(i_t(-8, 2, 0, 2, O_IMM));
    emit(s_w(4, 5, 2));
    emit(i_t(4, 2, 2, 9, O_LOAD));
    emit(s_w(0, 9, 3));
    reset_cpu;
    run_to(32'h0001_0014, 50, "stk");
    check("stk_cnt", st_addr.size(), 32'd2);
    check("stk_addr", st_addr[0], 32'hBFFF_FFEC);
    check("stk_data", st_data[0], 32'd7);
    check("stk_mem", smem[59], 32'd7);
    check("lw_x9", dmem[0], 32'd7);

    // branches and jumps, checked by exact PC sequence
    clear_mem;
    emit(i_t(1, 0, 0, 5, O_IMM));
    emit(b_t(8, 5, 0, 0));
    emit(b_t(8, 5, 0, 1));
    emit(i_t(99, 0, 0, 6, O_IMM));
    emit(j_t(8, 1));
    emit(j_t(12, 0));
    emit(i_t(0, 1, 0, 0, O_JALR));
    emit(NOP);
    emit(s_w(0, 1, 3));
    emit(b_t(8, 5, 0, 4));
    emit(b_t(8, 5, 0, 5));
    emit(NOP);
    emit(i_t(-1, 0, 0, 7, O_IMM));
    emit(b_t(8, 7, 0, 4));
    cf_exp = '{32'h10000, 32'h10004, 32'h10008, 32'h10010, 32'h10018, 32'h10014,
               32'h10020, 32'h10024, 32'h10028, 32'h10030, 32'h10034, 32'h1003C};
    reset_cpu;
    run_to(32'h0001_0040, 50, "cf");
    check("cf_len", trace.size(), 32'd12);
    for (int i = 0; i < 12; i++) check($sformatf("cf_pc%0d", i), trace[i], cf_exp[i]);
    check("cf_ra", dmem[0], 32'h0001_0014);

    // recursive factorial(5)
    clear_mem;
    emit(i_t(5, 0, 0, 10, O_IMM));
    emit(j_t(12, 1));
    emit(s_w(0, 10, 3));
    emit(j_t(0, 0));
    emit(i_t(-8, 2, 0, 2, O_IMM));
    emit(s_w(4, 1, 2));
    emit(s_w(0, 10, 2));
    emit(i_t(2, 0, 0, 5, O_IMM));
    emit(b_t(44, 10, 5, 4));
    emit(i_t(-1, 10, 0, 10, O_IMM));
    emit(j_t(-24, 1));
    emit(i_t(0, 2, 2, 6, O_LOAD));
    emit(i_t(0, 0, 0, 7, O_IMM));
    emit(b_t(16, 6, 0, 0));
    emit(r_t(0, 10, 7, 0, 7));
    emit(i_t(-1, 6, 0, 6, O_IMM));
    emit(j_t(-12, 0));
    emit(i_t(0, 7, 0, 10, O_IMM));
    emit(j_t(8, 0));
    emit(i_t(1, 0, 0, 10, O_IMM));
    emit(i_t(4, 2, 2, 1, O_LOAD));
    emit(i_t(8, 2, 0, 2, O_IMM));
    emit(i_t(0, 1, 0, 0, O_JALR));
    reset_cpu;
    run_to(32'h0001_000C, 2000, "fact");
    check("fact_result", dmem[0], 32'h0000_0078);
    check("fact_in_text", {31'b0, max_pc <= 32'h0001_0058}, 32'd1);
    check("fact_top_n", smem[58], 32'd5);
    check("fact_top_ra", smem[59], 32'h0001_0008);
    check("fact_leaf_n", smem[50], 32'd1);

    // unsupported encodings, x0 write and mul
    clear_mem;
    dmem[0] = 32'hDEAD_BEEF;
    dmem[2] = 32'hDEAD_BEEF;
    emit(i_t(6, 0, 0, 5, O_IMM));
    emit(i_t(7, 0, 0, 6, O_IMM));
    emit(32'h0000_000B);
    emit(i_t(5, 0, 0, 0, O_IMM));
    emit(i_t(100, 5, 3, 5, O_IMM));
    emit(s_w(0, 0, 3));
    emit(s_w(4, 5, 3));
    emit(r_t(1, 6, 5, 0, 7));
    emit(s_w(8, 7, 3));
    reset_cpu;
    run_to(32'h0001_0024, 50, "misc");
    check("misc_pc_bad_op", trace[3], 32'h0001_000C);
    check("misc_store_cnt", st_addr.size(), 32'd3);
    check("x0_zero", dmem[0], 32'h0);
    check("sltiu_nop", dmem[1], 32'd6);
`ifdef CHIP_MUL_EN
    check("mul", dmem[2], 32'd42);
`else
    check("mul_nop", dmem[2], 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
